// File: rtl/crc16_frame_checker.sv
// crc16_frame_checker: receive-side CRC-16-CCITT frame checker.
// Recomputes the CRC over each frame, including the two trailing CRC bytes,
// and checks the frame length. It forwards the payload with the CRC bytes
// stripped and issues a one-cycle verdict per frame.
module crc16_frame_checker #(
  parameter logic [15:0] INIT_VALUE = 16'hFFFF,
  parameter int          MAX_LEN    = 1024,
  parameter int          LEN_WIDTH  = $clog2(MAX_LEN + 2)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync_reset,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic                 in_eof,
  input  logic [7:0]           data_in,
  output logic                 out_valid,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic [7:0]           out_data,
  output logic                 frame_done,
  output logic                 crc_ok,
  output logic                 len_err,
  output logic                 sync_err,
  output logic [15:0]          rx_crc,
  output logic [LEN_WIDTH-1:0] frame_len
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DISCARD} state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_THREE = LEN_WIDTH'(3);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX   = LEN_WIDTH'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0] LEN_OVER  = LEN_WIDTH'(MAX_LEN + 1);

  // One byte of MSB-first CRC-16-CCITT (0x1021), folded into a byte-wide XOR form
  function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] d);
    logic [7:0]  x;
    logic [15:0] xw;
    x  = crc[15:8] ^ d;
    x  = x ^ (x >> 4);
    xw = {8'h00, x};
    return (crc << 8) ^ (xw << 12) ^ (xw << 5) ^ xw;
  endfunction

  state_t               state, state_n;
  logic [15:0]          crc, crc_n, crc_upd, crc_first;
  logic [LEN_WIDTH-1:0] len, len_n, len_inc;
  logic [7:0]           buf0, buf0_n, buf1, buf1_n;
  logic                 started, started_n;
  logic                 out_valid_n, out_sof_n, out_eof_n;
  logic [7:0]           out_data_n;
  logic                 frame_done_n, crc_ok_n, len_err_n, sync_err_n;
  logic [15:0]          rx_crc_n;
  logic [LEN_WIDTH-1:0] frame_len_n;
  logic                 eof_len_bad;

  // Next-state, datapath and registered-output computation for every accepted byte
  always_comb begin
    state_n      = state;
    crc_n        = crc;
    len_n        = len;
    buf0_n       = buf0;
    buf1_n       = buf1;
    started_n    = started;
    out_valid_n  = 1'b0;
    out_sof_n    = 1'b0;
    out_eof_n    = 1'b0;
    out_data_n   = out_data;
    frame_done_n = 1'b0;
    crc_ok_n     = crc_ok;
    len_err_n    = len_err;
    sync_err_n   = sync_err;
    rx_crc_n     = rx_crc;
    frame_len_n  = frame_len;
    crc_upd      = crc16_update(crc, data_in);
    crc_first    = crc16_update(INIT_VALUE, data_in);
    len_inc      = len + LEN_ONE;
    eof_len_bad  = (len_inc < LEN_THREE) || (len_inc > LEN_MAX);

    if (in_valid) begin
      case (state)
        IDLE, DISCARD: begin
          if (in_sof) begin
            crc_n     = crc_first;
            len_n     = LEN_ONE;
            buf0_n    = 8'h00;
            buf1_n    = data_in;
            started_n = 1'b0;
            if (in_eof) begin
              frame_done_n = 1'b1;
              crc_ok_n     = 1'b0;
              len_err_n    = 1'b1;
              sync_err_n   = 1'b0;
              rx_crc_n     = {8'h00, data_in};
              frame_len_n  = LEN_ONE;
              state_n      = IDLE;
            end else begin
              state_n = ACTIVE;
            end
          end else if (in_eof) begin
            state_n = IDLE;
          end
        end

        ACTIVE: begin
          if (in_sof) begin
            frame_done_n = 1'b1;
            crc_ok_n     = 1'b0;
            len_err_n    = (len < LEN_THREE);
            sync_err_n   = 1'b1;
            rx_crc_n     = {buf0, buf1};
            frame_len_n  = len;
            crc_n        = crc_first;
            len_n        = LEN_ONE;
            buf0_n       = 8'h00;
            buf1_n       = data_in;
            started_n    = 1'b0;
          end else if (in_eof) begin
            frame_done_n = 1'b1;
            len_err_n    = eof_len_bad;
            crc_ok_n     = (crc_upd == 16'h0000) && !eof_len_bad;
            sync_err_n   = 1'b0;
            rx_crc_n     = {buf1, data_in};
            frame_len_n  = len_inc;
            if (len_inc >= LEN_THREE) begin
              out_valid_n = 1'b1;
              out_sof_n   = !started;
              out_eof_n   = 1'b1;
              out_data_n  = buf0;
            end
            crc_n     = INIT_VALUE;
            len_n     = '0;
            buf0_n    = 8'h00;
            buf1_n    = 8'h00;
            started_n = 1'b0;
            state_n   = IDLE;
          end else if (len_inc == LEN_OVER) begin
            frame_done_n = 1'b1;
            crc_ok_n     = 1'b0;
            len_err_n    = 1'b1;
            sync_err_n   = 1'b0;
            rx_crc_n     = {buf1, data_in};
            frame_len_n  = LEN_OVER;
            state_n      = DISCARD;
          end else begin
            crc_n  = crc_upd;
            len_n  = len_inc;
            buf0_n = buf1;
            buf1_n = data_in;
            if (len_inc >= LEN_THREE) begin
              out_valid_n = 1'b1;
              out_sof_n   = !started;
              out_data_n  = buf0;
              started_n   = 1'b1;
            end
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  // State, datapath and output registers; either reset source restores the idle state
  always_ff @(posedge clk) begin
    if (!reset_n || sync_reset) begin
      state      <= IDLE;
      crc        <= INIT_VALUE;
      len        <= '0;
      buf0       <= 8'h00;
      buf1       <= 8'h00;
      started    <= 1'b0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_data   <= 8'h00;
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      len_err    <= 1'b0;
      sync_err   <= 1'b0;
      rx_crc     <= 16'h0000;
      frame_len  <= '0;
    end else begin
      state      <= state_n;
      crc        <= crc_n;
      len        <= len_n;
      buf0       <= buf0_n;
      buf1       <= buf1_n;
      started    <= started_n;
      out_valid  <= out_valid_n;
      out_sof    <= out_sof_n;
      out_eof    <= out_eof_n;
      out_data   <= out_data_n;
      frame_done <= frame_done_n;
      crc_ok     <= crc_ok_n;
      len_err    <= len_err_n;
      sync_err   <= sync_err_n;
      rx_crc     <= rx_crc_n;
      frame_len  <= frame_len_n;
    end
  end

endmodule
